usb_rx_packet_decoder: RTL and testbench
========================================

Name: usb_rx_packet_decoder

Overview:
- Receive-side bit-level packet decoder sitting between the sampled USB line (DP/DN after synchronizer and bit-centre recovery) and the clk48 byte backend.
- Functions: J/K/SE0 line-state decode, NRZI decode, SYNC detection, bit unstuffing, LSB-first byte assembly and EOP detection.
- Output: bytes through a valid/accept handshake, flagged with last-byte and keep/drop status.
- Counterpart of usb_tx: a usb_tx output looped into this block must reproduce the transmitted bytes exactly.

Parameters:
SYNC_MIN_ZEROS, 5, minimum decoded 0 bits before the SYNC-terminating 1; tolerates lost leading SYNC bits.
MIN_SE0_BITS, 1, consecutive SE0 samples required to recognise EOP.

Ports:
clk48  input  1  the single clock; all logic on its rising edge.
RST  input  1  synchronous, active-high reset.
rxBitValid  input  1  one-cycle strobe at each bit centre, nominally every 4th clk48 cycle; dataInP/N are sampled only when it is high.
dataInP  input  1  synchronized D+ level.
dataInN  input  1  synchronized D- level.
rxAcceptNewData  input  1  backend takes the current output byte this cycle.
rxDataValid  output  1  rxData holds an unconsumed byte.
rxIsLastByte  output  1  current byte is the final byte of its packet.
rxData  output  8  received byte.
keepPacket  output  1  packet ended cleanly; meaningful only while rxDataValid && rxIsLastByte.
receiving  output  1  high from SYNC completion until EOP or abort.

Behaviour:
- Line states: J = P1/N0, K = P0/N1, SE0 = P0/N0, SE1 = P1/N1.
- SE1 is an error in every state except IDLE, where it is ignored.
- NRZI decode: decoded bit = 1 when the level equals the previous J/K level, 0 on a transition. The previous level resets to J and is reloaded to J at EOP completion.
- FSM states:
  - IDLE: on a K sample, go to SYNC with zeroCnt=1.
  - SYNC: a decoded 0 increments zeroCnt (saturating). A decoded 1 goes to DATA when zeroCnt >= SYNC_MIN_ZEROS, otherwise to IDLE with no output. SE0 goes to EOP with no output.
  - DATA: decoded bits pass through the unstuffer.
    - onesCnt is set to 1 on SYNC completion, increments on 1, clears on 0.
    - After 6 ones the next bit is dropped if it is 0. If it is 1, set stuffErr and go to ABORT.
    - Kept bits shift into the assembly register LSB-first. bitCnt runs 0..7; on wrap a completed byte is produced.
    - SE0 goes to EOP.
  - EOP: count SE0 samples. A J after >= MIN_SE0_BITS SE0 samples completes the packet, then IDLE. A K before the J sets an error, then ABORT.
  - ABORT: ignore data and wait for SE0 followed by J, then IDLE.
- Buffering:
  - Completed bytes enter a one-entry pending register.
  - The previously pending byte moves to the output register when the output is empty or accepted in the same cycle, with rxIsLastByte=0.
  - The pending byte is held back so the last byte can be tagged at packet end.
- Packet end (EOP J, or end of ABORT):
  - The pending byte moves to output with rxIsLastByte=1.
  - keepPacket=1 only if: no stuff error, no SE1, no overflow, bitCnt==0 at the SE0, and the end did not come through ABORT.
  - No pending byte (zero-byte packet) means no output.
  - If the output is still occupied, the last byte waits in pending; that wait is not an error.
- Overflow: a byte completes while both pending and output are occupied and the output is not accepted. The new byte is dropped and an error is set; keepPacket is 0 for this packet.
- Handshake:
  - rxData, rxIsLastByte and keepPacket are stable while rxDataValid=1 and not accepted.
  - rxDataValid drops the cycle after acceptance unless pending refills it that same edge.
- receiving rises the cycle after the SYNC-terminating 1 is sampled and falls on EOP completion or entry to ABORT.
- Reset: state IDLE; all counters and flags cleared; pending empty; rxDataValid=0, rxIsLastByte=0, rxData=0, keepPacket=0, receiving=0.
- Reset mid-packet discards everything with no last-byte flush.
- Latency: a byte appears on rxData 2–3 cycles after the strobe that completes the following byte or the EOP.

Optional Feature:
- Macro: USB_RX_ERR_COUNT_EN.
- When defined: adds output rxErrCount [7:0]. It increments once per packet ending with keepPacket=0 (including zero-byte error packets), saturates at 255 and resets to 0.
- When undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Clean packet: SYNC plus bytes 0xC3, 0x01, 0x02, then SE0 SE0 J, with accept held high → rxData 0xC3, 0x01, 0x02; last=1 only on 0x02; keepPacket=1; receiving low after J.
- Stuffing: byte 0xFF, 0xFF with stuffed zeros inserted → outputs 0xFF, 0xFF with keepPacket=1. The same packet with one stuffed 0 flipped to 1 → ABORT; after EOP, flushed byte has last=1 and keepPacket=0.
- Backpressure: accept held 0 while 3 bytes arrive → third byte dropped (overflow). Release accept → 2 bytes delivered, the second with last=1 and keepPacket=0.
- Misaligned EOP: 0xA5 plus 3 extra bits, then EOP → 0xA5 delivered with last=1 and keepPacket=0.
- Short SYNC (only 3 zeros before the 1) → no output, receiving stays 0, block returns to IDLE and accepts the next valid packet.
- Reset asserted mid-byte, then a clean single-byte 0x5A packet → only 0x5A delivered, with last=1 and keepPacket=1.

Source files
------------

// File: rtl/usb_rx_packet_decoder.sv
// USB receive decoder: line state, NRZI, SYNC, unstuffing and LSB-first byte assembly into a pending stage plus output register.
// Latency: a byte reaches rxData 2-3 clk48 cycles after the strobe that completes the next byte or the EOP J.
// Backpressure: output holds until rxAcceptNewData; a byte completing with both stages full is dropped and the packet marked bad.
// Build option USB_RX_ERR_COUNT_EN adds rxErrCount, a saturating count of packets ending with keepPacket=0.
module usb_rx_packet_decoder #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int MIN_SE0_BITS   = 1
) (
  input  logic       clk48,
  input  logic       RST,
  input  logic       rxBitValid,
  input  logic       dataInP,
  input  logic       dataInN,
  input  logic       rxAcceptNewData,
  output logic       rxDataValid,
  output logic       rxIsLastByte,
  output logic [7:0] rxData,
  output logic       keepPacket,
`ifdef USB_RX_ERR_COUNT_EN
  output logic [7:0] rxErrCount,
`endif
  output logic       receiving
);

  localparam logic [3:0] SYNC_MIN = 4'(SYNC_MIN_ZEROS);
  localparam logic [3:0] SE0_MIN  = 4'(MIN_SE0_BITS);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;

  state_t     state;
  logic       prevP;
  logic [3:0] zeroCnt;
  logic [3:0] se0Cnt;
  logic [2:0] onesCnt;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic       pktActive;
  logic       pktErr;
  logic       alignedAtSe0;
  logic       sawSe0;
  logic       byteStb;
  logic [7:0] byteDat;
  logic       endStb;
  logic       endClean;
  logic       pendVld;
  logic       pendLast;
  logic       pendKeep;
  logic [7:0] pendDat;

  logic       lineJ, lineK, lineSe0, lineSe1, bitIn, outFree, endKeep;
  logic [7:0] assembled;

  assign lineJ     = dataInP & ~dataInN;
  assign lineK     = ~dataInP & dataInN;
  assign lineSe0   = ~dataInP & ~dataInN;
  assign lineSe1   = dataInP & dataInN;
  assign bitIn     = (dataInP == prevP);
  assign assembled = {bitIn, shiftReg[7:1]};
  assign outFree   = ~rxDataValid | rxAcceptNewData;
  assign endKeep   = endClean & ~pktErr;

  always_ff @(posedge clk48) begin
    if (RST) begin
      state        <= IDLE;
      prevP        <= 1'b1;
      zeroCnt      <= '0;
      se0Cnt       <= '0;
      onesCnt      <= '0;
      bitCnt       <= '0;
      shiftReg     <= '0;
      pktActive    <= 1'b0;
      pktErr       <= 1'b0;
      alignedAtSe0 <= 1'b0;
      sawSe0       <= 1'b0;
      byteStb      <= 1'b0;
      byteDat      <= '0;
      endStb       <= 1'b0;
      endClean     <= 1'b0;
      pendVld      <= 1'b0;
      pendLast     <= 1'b0;
      pendKeep     <= 1'b0;
      pendDat      <= '0;
      rxDataValid  <= 1'b0;
      rxIsLastByte <= 1'b0;
      rxData       <= '0;
      keepPacket   <= 1'b0;
      receiving    <= 1'b0;
    end else begin
      byteStb <= 1'b0;
      endStb  <= 1'b0;
      if (rxBitValid) begin
        if (lineJ | lineK) prevP <= dataInP;
        case (state)
          IDLE: begin
            if (lineK) begin
              state   <= SYNC;
              zeroCnt <= 4'd1;
            end
          end
          SYNC: begin
            if (lineSe1) begin
              state  <= ABORT;
              sawSe0 <= 1'b0;
            end else if (lineSe0) begin
              state  <= EOP;
              se0Cnt <= 4'd1;
            end else if (!bitIn) begin
              if (zeroCnt != 4'hF) zeroCnt <= zeroCnt + 4'd1;
            end else if (zeroCnt >= SYNC_MIN) begin
              state     <= DATA;
              onesCnt   <= 3'd1;
              bitCnt    <= 3'd0;
              pktActive <= 1'b1;
              pktErr    <= 1'b0;
              receiving <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          DATA: begin
            if (lineSe0) begin
              state        <= EOP;
              se0Cnt       <= 4'd1;
              alignedAtSe0 <= (bitCnt == 3'd0);
            end else if (lineSe1 || (onesCnt == 3'd6 && bitIn)) begin
              pktErr    <= 1'b1;
              state     <= ABORT;
              sawSe0    <= 1'b0;
              receiving <= 1'b0;
            end else if (onesCnt == 3'd6) begin
              onesCnt <= 3'd0;  // stuffed zero: discard
            end else begin
              onesCnt  <= bitIn ? onesCnt + 3'd1 : 3'd0;
              shiftReg <= assembled;
              bitCnt   <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                byteStb <= 1'b1;
                byteDat <= assembled;
              end
            end
          end
          EOP: begin
            if (lineSe0) begin
              if (se0Cnt != 4'hF) se0Cnt <= se0Cnt + 4'd1;
            end else if (lineJ && se0Cnt >= SE0_MIN) begin
              state     <= IDLE;
              prevP     <= 1'b1;
              receiving <= 1'b0;
              endStb    <= pktActive;
              endClean  <= alignedAtSe0;
              pktActive <= 1'b0;
            end else begin
              pktErr    <= 1'b1;
              state     <= ABORT;
              sawSe0    <= 1'b0;
              receiving <= 1'b0;
            end
          end
          ABORT: begin
            if (lineSe0) begin
              sawSe0 <= 1'b1;
            end else if (lineJ && sawSe0) begin
              state     <= IDLE;
              prevP     <= 1'b1;
              endStb    <= pktActive;
              endClean  <= 1'b0;
              pktActive <= 1'b0;
            end else begin
              sawSe0 <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Pending stage holds one byte back so the packet's final byte can be tagged last.
      if (rxAcceptNewData) rxDataValid <= 1'b0;
      if (byteStb) begin
        if (!pendVld) begin
          pendVld  <= 1'b1;
          pendDat  <= byteDat;
          pendLast <= 1'b0;
          pendKeep <= 1'b0;
        end else if (outFree) begin
          rxDataValid  <= 1'b1;
          rxData       <= pendDat;
          rxIsLastByte <= pendLast;
          keepPacket   <= pendKeep;
          pendDat      <= byteDat;
          pendLast     <= 1'b0;
          pendKeep     <= 1'b0;
        end else begin
          pktErr <= 1'b1;
        end
      end else if (endStb && pendVld && !pendLast) begin
        if (outFree) begin
          rxDataValid  <= 1'b1;
          rxData       <= pendDat;
          rxIsLastByte <= 1'b1;
          keepPacket   <= endKeep;
          pendVld      <= 1'b0;
        end else begin
          pendLast <= 1'b1;
          pendKeep <= endKeep;
        end
      end else if (pendVld && pendLast && outFree) begin
        rxDataValid  <= 1'b1;
        rxData       <= pendDat;
        rxIsLastByte <= 1'b1;
        keepPacket   <= pendKeep;
        pendVld      <= 1'b0;
      end
    end
  end

`ifdef USB_RX_ERR_COUNT_EN
  always_ff @(posedge clk48) begin
    if (RST) begin
      rxErrCount <= '0;
    end else if (endStb && !endKeep && rxErrCount != 8'hFF) begin
      rxErrCount <= rxErrCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Bench for usb_rx_packet_decoder: an NRZI/stuffing line encoder drives packets; a scoreboard queue is filled from a packet-level model.
module tb_usb_rx_packet_decoder;

  logic       clk48 = 1'b0;
  logic       RST = 1'b1;
  logic       rxBitValid = 1'b0;
  logic       dataInP = 1'b1;
  logic       dataInN = 1'b0;
  logic       rxAcceptNewData = 1'b0;
  logic       rxDataValid, rxIsLastByte, keepPacket, receiving;
  logic [7:0] rxData;
`ifdef USB_RX_ERR_COUNT_EN
  logic [7:0] rxErrCount;
`endif

  usb_rx_packet_decoder dut (
    .clk48          (clk48),
    .RST            (RST),
    .rxBitValid     (rxBitValid),
    .dataInP        (dataInP),
    .dataInN        (dataInN),
    .rxAcceptNewData(rxAcceptNewData),
    .rxDataValid    (rxDataValid),
    .rxIsLastByte   (rxIsLastByte),
    .rxData         (rxData),
    .keepPacket     (keepPacket),
`ifdef USB_RX_ERR_COUNT_EN
    .rxErrCount     (rxErrCount),
`endif
    .receiving      (receiving)
  );

  always #5 clk48 = ~clk48;

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
    logic       keep;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] pktBytes[$];
  int         checkCnt = 0;
  int         passCnt = 0;
  int         acceptMode = 0;  // 0 random, 1 held low, 2 held high
  int         stall = 0;
  logic       lvl = 1'b1;
  logic       watchRecv = 1'b0;
  logic       recvSeen = 1'b0;
  logic       heldVld = 1'b0;
  logic [9:0] heldVal;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Backend acceptor
  initial begin
    forever begin
      @(posedge clk48);
      #1;
      case (acceptMode)
        1: rxAcceptNewData = 1'b0;
        2: rxAcceptNewData = 1'b1;
        default: begin
          rxAcceptNewData = (stall >= 3) || ($urandom_range(0, 1) == 1);
          stall = rxAcceptNewData ? 0 : stall + 1;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and checks holding stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk48);
      if (watchRecv && receiving) recvSeen = 1'b1;
      if (RST || !rxDataValid) begin
        heldVld = 1'b0;
      end else begin
        if (heldVld) check("hold_stable", {rxData, rxIsLastByte, keepPacket}, heldVal);
        if (rxAcceptNewData) begin
          heldVld = 1'b0;
          if (expQ.size() == 0) begin
            checkCnt++;
            $display("FAIL unexpected_byte: got %02h last=%0b, expected no output", rxData, rxIsLastByte);
          end else begin
            e = expQ.pop_front();
            check("data", rxData, e.dat);
            check("last", rxIsLastByte, e.last);
            if (e.last) check("keep", keepPacket, e.keep);
          end
        end else begin
          heldVld = 1'b1;
          heldVal = {rxData, rxIsLastByte, keepPacket};
        end
      end
    end
  end

  task automatic sendLine(input logic p, input logic n);
    @(posedge clk48);
    #1;
    dataInP = p;
    dataInN = n;
    rxBitValid = 1'b1;
    @(posedge clk48);
    #1;
    rxBitValid = 1'b0;
    repeat (2) @(posedge clk48);
  endtask

  task automatic sendBit(input logic b);
    if (!b) lvl = ~lvl;
    sendLine(lvl, ~lvl);
  endtask

  task automatic sendEop();
    sendLine(1'b0, 1'b0);
    sendLine(1'b0, 1'b0);
    sendLine(1'b1, 1'b0);
    lvl = 1'b1;
  endtask

  // Sends pktBytes with `extra` trailing bits; flipN selects a stuffed zero to corrupt (-1 none).
  task automatic sendPacket(input int extra, input int flipN, input int syncZeros);
    logic dataBits[$];
    int   stuffPos[$];
    int   ones, deliver, sp;
    logic keep;
    exp_t e;
    foreach (pktBytes[i])
      for (int b = 0; b < 8; b++) dataBits.push_back(pktBytes[i][b]);
    for (int i = 0; i < extra; i++) dataBits.push_back(1'($urandom_range(0, 1)));
    ones = 1;
    foreach (dataBits[i]) begin
      ones = dataBits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        stuffPos.push_back(i);
        ones = 0;
      end
    end
    // Packet-level expectation: aborted packets keep only bytes finished before the bad stuff bit.
    if (flipN >= 0 && flipN < stuffPos.size()) begin
      deliver = (stuffPos[flipN] + 1) / 8;
      keep = 1'b0;
    end else begin
      deliver = pktBytes.size();
      keep = (extra == 0);
    end
    if (acceptMode == 1 && deliver > 2) begin
      deliver = 2;
      keep = 1'b0;
    end
    for (int i = 0; i < deliver; i++) begin
      e.dat = pktBytes[i];
      e.last = (i == deliver - 1);
      e.keep = keep;
      expQ.push_back(e);
    end
    for (int i = 0; i < syncZeros; i++) sendBit(1'b0);
    sendBit(1'b1);
    #1;
    check("recv_after_sync", receiving, 1);
    sp = 0;
    foreach (dataBits[i]) begin
      sendBit(dataBits[i]);
      if (sp < stuffPos.size() && stuffPos[sp] == i) begin
        sendBit(sp == flipN);
        sp++;
      end
    end
    sendEop();
    #1;
    check("recv_after_eop", receiving, 0);
  endtask

  task automatic waitDrain();
    int c = 0;
    while (expQ.size() != 0 && c < 2000) begin
      @(posedge clk48);
      c++;
    end
    check("drain_queue_empty", expQ.size(), 0);
    repeat (4) @(posedge clk48);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, extra, flipN;
    repeat (4) @(posedge clk48);
    #1;
    RST = 1'b0;
    @(negedge clk48);
    check("rst_valid", rxDataValid, 0);
    check("rst_last", rxIsLastByte, 0);
    check("rst_data", rxData, 0);
    check("rst_keep", keepPacket, 0);
    check("rst_recv", receiving, 0);
    sendLine(1'b1, 1'b0);
    sendLine(1'b1, 1'b0);

    // Clean packet, accept held high
    acceptMode = 2;
    pktBytes = '{8'hC3, 8'h01, 8'h02};
    sendPacket(0, -1, 7);
    waitDrain();
    acceptMode = 0;

    // Stuffing, then a corrupted stuff bit
    pktBytes = '{8'hFF, 8'hFF};
    sendPacket(0, -1, 7);
    waitDrain();
    sendPacket(0, 1, 7);
    waitDrain();

    // Backpressure: three bytes with accept held low
    acceptMode = 1;
    repeat (3) @(posedge clk48);
    pktBytes = '{8'($urandom), 8'($urandom), 8'($urandom)};
    sendPacket(0, -1, 7);
    repeat (20) @(posedge clk48);
    #1;
    check("bp_output_held", rxDataValid, 1);
    acceptMode = 0;
    waitDrain();

    // Misaligned EOP
    pktBytes = '{8'hA5};
    sendPacket(3, -1, 7);
    waitDrain();

    // Short SYNC yields nothing, then a valid packet
    watchRecv = 1'b1;
    recvSeen = 1'b0;
    for (int i = 0; i < 3; i++) sendBit(1'b0);
    sendBit(1'b1);
    sendEop();
    repeat (4) @(posedge clk48);
    watchRecv = 1'b0;
    check("short_sync_recv", recvSeen, 0);
    pktBytes = '{8'($urandom), 8'($urandom)};
    sendPacket(0, -1, 7);
    waitDrain();

    // Reset mid-byte, then a clean single-byte packet
    for (int i = 0; i < 7; i++) sendBit(1'b0);
    sendBit(1'b1);
    for (int b = 0; b < 8; b++) sendBit(b[0]);
    for (int b = 0; b < 3; b++) sendBit(1'b1);
    @(posedge clk48);
    #1;
    RST = 1'b1;
    dataInP = 1'b1;
    dataInN = 1'b0;
    lvl = 1'b1;
    repeat (2) @(posedge clk48);
    #1;
    RST = 1'b0;
    @(negedge clk48);
    check("rst_mid_recv", receiving, 0);
    check("rst_mid_valid", rxDataValid, 0);
    pktBytes = '{8'h5A};
    sendPacket(0, -1, 7);
    waitDrain();

    // Randomised packets
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, 5);
      pktBytes.delete();
      for (int i = 0; i < n; i++)
        pktBytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      extra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      flipN = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
      acceptMode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      sendPacket(extra, flipN, $urandom_range(5, 7));
      waitDrain();
      acceptMode = 0;
    end

    repeat (10) @(posedge clk48);
    #1;
    check("final_valid", rxDataValid, 0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
